// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and helpers for the serial chunk adder.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that must hold values 0 .. n-1 (never narrower than 1 bit).
  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Request/result bundle between the ALU datapath and the serial chunk adder.
//
// Handshake: the master raises start with a, b, sub and carryIn valid; the
// request is taken only on a rising edge where the adder is idle (busy=0 and
// done=0), otherwise it is dropped, never queued. The adder answers with a
// single-cycle done pulse. sum/carryOut/overflow are valid from that pulse
// and stay put until the next accepted request completes.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 32
);
  import serial_chunk_adder_pkg::*;

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
  logic             overflow;
  state_t           state;     // FSM state, exported for checkers

  modport master (
    output start, sub, a, b, carryIn,
    input  busy, done, sum, carryOut, overflow, state
  );

  modport slave (
    input  start, sub, a, b, carryIn,
    output busy, done, sum, carryOut, overflow, state
  );

endinterface

// File: rtl/serial_chunk_adder_chunk_ripple_adder.sv
// CHUNK-bit ripple-carry adder slice. Besides the carry out it exposes the
// carry into its top bit so the caller can form signed overflow.
module chunk_ripple_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  logic [CHUNK:0] c;

  // Full-adder chain from bit 0 upwards.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout  = c[CHUNK];
    c_top = c[CHUNK-1];
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first, over
// WIDTH/CHUNK RUN cycles. Results land in output registers only at the
// RUN->DONE edge so they stay stable while a new operation runs.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 1
) (
  input logic                 clk,
  input logic                 rst,
  serial_chunk_adder_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = count_width(NCHUNK);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("serial_chunk_adder: illegal WIDTH/CHUNK combination");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] chunk_ext;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;
  logic             ov_q;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_ctop;
  logic             last;

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_sh[CHUNK-1:0]),
    .b     (b_sh[CHUNK-1:0]),
    .cin   (carry_q),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_top (chunk_ctop)
  );

  assign last      = (count == CW'(NCHUNK - 1));
  // New chunk enters at the top while earlier chunks move down; after the
  // last chunk the LSB chunk sits at bit 0.
  assign chunk_ext = WIDTH'(chunk_sum);
  assign res_nxt   = (res_sh >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, leave RUN after the last chunk, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE:                state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-chunk accumulation and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.carryIn;
            count   <= '0;
          end
        end
        ST_RUN: begin
          a_sh    <= a_sh >> CHUNK;
          b_sh    <= b_sh >> CHUNK;
          res_sh  <= res_nxt;
          carry_q <= chunk_cout;
          count   <= count + CW'(1);
          if (last) begin
            sum_q <= res_nxt;
            co_q  <= chunk_cout;
            ov_q  <= chunk_ctop ^ chunk_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == ST_RUN);
  assign bus.done     = (state == ST_DONE);
  assign bus.sum      = sum_q;
  assign bus.carryOut = co_q;
  assign bus.overflow = ov_q;
  assign bus.state    = state;

endmodule
